// File: rtl/reg_bank_if.sv
// Write/observe bus for reg_bank: write request in, flat register image, ack and commit count out.
interface reg_bank_if #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
);
    logic                     wr_en_i;
    logic [ADDR_W-1:0]        wr_addr_i;
    logic [WIDTH-1:0]         wr_data_i;
    logic [DEPTH*WIDTH-1:0]   regs_o;
    logic                     wr_ack_o;
    logic [7:0]               wr_cnt_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i,
        input  regs_o, wr_ack_o, wr_cnt_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i,
        output regs_o, wr_ack_o, wr_cnt_o
    );
endinterface

// File: rtl/reg_bank.sv
// Register-file storage: DEPTH x WIDTH flops, one-hot write decode, flat output bus.
// Optional macro REG_BANK_ZERO_REG_EN hardwires register DEPTH-1 to zero.
module reg_bank #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    reg_bank_if.slave   bus
);

`ifdef REG_BANK_ZERO_REG_EN
    localparam int NREG = DEPTH - 1;
`else
    localparam int NREG = DEPTH;
`endif

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]  dec_s;
    logic             ack_q;
    logic             ack_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;

    // Decode covers only real flops, so out-of-range and zero-register writes never commit.
    always_comb begin
        dec_s = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            dec_s[r] = bus.wr_en_i & (bus.wr_addr_i == ADDR_W'(r));
        end
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = dec_s[r] ? bus.wr_data_i : regs_q[r];
        end
        ack_d = |dec_s;
        cnt_d = ack_d ? (cnt_q + 8'd1) : cnt_q;
    end

    // State update; reset wins over a write presented in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= {WIDTH{1'b0}};
            end
            ack_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
            ack_q <= ack_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_out
        assign bus.regs_o[r*WIDTH +: WIDTH] = regs_q[r];
    end

`ifdef REG_BANK_ZERO_REG_EN
    assign bus.regs_o[(DEPTH-1)*WIDTH +: WIDTH] = {WIDTH{1'b0}};
`endif

    assign bus.wr_ack_o = ack_q;
    assign bus.wr_cnt_o = cnt_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic against an array model.
module tb_reg_bank;
    localparam int WIDTH  = 64;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
`ifdef REG_BANK_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [WIDTH-1:0] m_regs [DEPTH];
    int               m_cnt = 0;
    bit               m_ack = 1'b0;

    reg_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // One clock: drive inputs, take the edge, then advance the model by the written rules.
    task automatic step(input bit rst, input bit en, input logic [ADDR_W-1:0] a,
                        input logic [WIDTH-1:0] d);
        reset_i       = rst;
        bus.wr_en_i   = en;
        bus.wr_addr_i = a;
        bus.wr_data_i = d;
        @(posedge clk_i);
        #1;
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) m_regs[r] = '0;
            m_cnt = 0;
            m_ack = 1'b0;
        end else if (en && (int'(a) < DEPTH) && !(ZERO_EN && int'(a) == DEPTH - 1)) begin
            m_regs[a] = d;
            m_cnt     = (m_cnt + 1) % 256;
            m_ack     = 1'b1;
        end else begin
            m_ack = 1'b0;
        end
        reset_i     = 1'b0;
        bus.wr_en_i = 1'b0;
    endtask

    function automatic int first_bad_slice();
        for (int r = 0; r < DEPTH; r++)
            if (bus.regs_o[r*WIDTH +: WIDTH] !== m_regs[r]) return r;
        return -1;
    endfunction

    task automatic test_reset();
        int bad;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, ADDR_W'($urandom_range(0, DEPTH-1)), {$urandom, $urandom});
        step(1'b1, 1'b1, 5'd2, 64'h1234);
        bad = first_bad_slice();
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL reset_regs slice=%0d got=%h want=0", bad, bus.regs_o[bad*WIDTH +: WIDTH]);
        end
        checks++;
        if (bus.wr_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack got=%b want=0", bus.wr_ack_o);
        end
        checks++;
        if (bus.wr_cnt_o !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d want=0", bus.wr_cnt_o);
        end
    endtask

    task automatic test_write_readback();
        int bad;
        step(1'b0, 1'b1, 5'd3, 64'hDEADBEEF_0123_4567);
        checks++;
        if (bus.regs_o[3*WIDTH +: WIDTH] !== 64'hDEADBEEF_0123_4567) begin
            failures++;
            $display("FAIL wr_slice3 got=%h want=deadbeef01234567", bus.regs_o[3*WIDTH +: WIDTH]);
        end
        bad = first_bad_slice();
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL wr_others slice=%0d got=%h want=%h", bad, bus.regs_o[bad*WIDTH +: WIDTH], m_regs[bad]);
        end
        checks++;
        if (bus.wr_ack_o !== 1'b1 || bus.wr_cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL wr_ack_cnt got=%b/%0d want=1/1", bus.wr_ack_o, bus.wr_cnt_o);
        end
        step(1'b0, 1'b0, 5'd0, 64'h0);
        checks++;
        if (bus.wr_ack_o !== 1'b0 || bus.wr_cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL wr_idle got=%b/%0d want=0/1", bus.wr_ack_o, bus.wr_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] base;
        base = bus.wr_cnt_o;
        step(1'b0, 1'b1, 5'd5, 64'h1);
        checks++;
        if (bus.wr_ack_o !== 1'b1 || bus.regs_o[5*WIDTH +: WIDTH] !== 64'h1) begin
            failures++;
            $display("FAIL b2b_first got ack=%b s5=%h want 1/1", bus.wr_ack_o, bus.regs_o[5*WIDTH +: WIDTH]);
        end
        step(1'b0, 1'b1, 5'd5, 64'h2);
        checks++;
        if (bus.wr_ack_o !== 1'b1 || bus.regs_o[5*WIDTH +: WIDTH] !== 64'h2) begin
            failures++;
            $display("FAIL b2b_second got ack=%b s5=%h want 1/2", bus.wr_ack_o, bus.regs_o[5*WIDTH +: WIDTH]);
        end
        checks++;
        if (bus.wr_cnt_o !== base + 8'd2) begin
            failures++;
            $display("FAIL b2b_cnt got=%0d want=%0d", bus.wr_cnt_o, base + 8'd2);
        end
        step(1'b0, 1'b0, 5'd5, 64'h3);
        checks++;
        if (bus.wr_ack_o !== 1'b0 || bus.regs_o[5*WIDTH +: WIDTH] !== 64'h2) begin
            failures++;
            $display("FAIL b2b_idle got ack=%b s5=%h want 0/2", bus.wr_ack_o, bus.regs_o[5*WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_reset_priority();
        step(1'b1, 1'b1, 5'd7, 64'hFF);
        checks++;
        if (bus.regs_o[7*WIDTH +: WIDTH] !== 64'h0 || bus.wr_ack_o !== 1'b0 || bus.wr_cnt_o !== 8'd0) begin
            failures++;
            $display("FAIL rst_prio got s7=%h ack=%b cnt=%0d want 0/0/0",
                     bus.regs_o[7*WIDTH +: WIDTH], bus.wr_ack_o, bus.wr_cnt_o);
        end
        step(1'b0, 1'b1, 5'd7, 64'hFF);
        checks++;
        if (bus.regs_o[7*WIDTH +: WIDTH] !== 64'hFF || bus.wr_ack_o !== 1'b1 || bus.wr_cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL rst_after got s7=%h ack=%b cnt=%0d want ff/1/1",
                     bus.regs_o[7*WIDTH +: WIDTH], bus.wr_ack_o, bus.wr_cnt_o);
        end
    endtask

    task automatic test_zero_reg();
        logic [WIDTH-1:0] want_v;
        logic             want_a;
        logic [7:0]       want_c;
        want_v = ZERO_EN ? 64'h0 : 64'hAAAA;
        want_a = ZERO_EN ? 1'b0 : 1'b1;
        want_c = ZERO_EN ? bus.wr_cnt_o : bus.wr_cnt_o + 8'd1;
        step(1'b0, 1'b1, 5'd31, 64'hAAAA);
        checks++;
        if (bus.regs_o[31*WIDTH +: WIDTH] !== want_v || bus.wr_ack_o !== want_a || bus.wr_cnt_o !== want_c) begin
            failures++;
            $display("FAIL zero_reg got s31=%h ack=%b cnt=%0d want %h/%b/%0d",
                     bus.regs_o[31*WIDTH +: WIDTH], bus.wr_ack_o, bus.wr_cnt_o, want_v, want_a, want_c);
        end
    endtask

    task automatic test_wrap_exhaustive();
        bit saw_wrap;
        int bad;
        int errs;
        logic [7:0] prev;
        saw_wrap = 1'b0;
        errs     = 0;
        step(1'b1, 1'b0, 5'd0, 64'h0);
        for (int round = 0; round < 9; round++) begin
            for (int a = 0; a < DEPTH; a++) begin
                prev = bus.wr_cnt_o;
                step(1'b0, 1'b1, ADDR_W'(a), 64'(a));
                if (prev == 8'd255 && bus.wr_cnt_o == 8'd0) saw_wrap = 1'b1;
                if (bus.wr_cnt_o !== 8'(m_cnt) || bus.wr_ack_o !== m_ack) begin
                    if (errs == 0)
                        $display("FAIL wrap_step addr=%0d got cnt=%0d ack=%b want %0d/%b",
                                 a, bus.wr_cnt_o, bus.wr_ack_o, m_cnt, m_ack);
                    errs++;
                end
            end
        end
        checks++;
        if (errs !== 0) failures++;
        checks++;
        if (saw_wrap !== 1'b1) begin
            failures++;
            $display("FAIL wrap_seen got=%b want=1", saw_wrap);
        end
        bad = first_bad_slice();
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL exh_slices slice=%0d got=%h want=%h", bad, bus.regs_o[bad*WIDTH +: WIDTH], m_regs[bad]);
        end
        checks++;
        if (bus.regs_o[30*WIDTH +: WIDTH] !== 64'd30) begin
            failures++;
            $display("FAIL exh_slice30 got=%h want=1e", bus.regs_o[30*WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_random();
        int errs;
        int bad;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 ADDR_W'($urandom_range(0, DEPTH-1)), {$urandom, $urandom});
            bad = first_bad_slice();
            if (bad != -1 || bus.wr_ack_o !== m_ack || bus.wr_cnt_o !== 8'(m_cnt)) begin
                if (errs < 3)
                    $display("FAIL rand cyc=%0d slice=%0d ack=%b/%b cnt=%0d/%0d",
                             i, bad, bus.wr_ack_o, m_ack, bus.wr_cnt_o, m_cnt);
                errs++;
            end
        end
        checks++;
        if (errs !== 0) failures++;
    endtask

    initial begin
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        step(1'b1, 1'b0, 5'd0, 64'h0);
        test_reset();
        test_write_readback();
        test_back_to_back();
        test_reset_priority();
        test_zero_reg();
        test_wrap_exhaustive();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
